// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard and forwarding controller for a 5-stage MIPS pipeline. A shadow
//   copy of the E, M and W stages is kept here. It holds the destination
//   register, the remaining time until the result exists (tnew) and the
//   source registers that later forward muxes need. The shadow is fed only
//   from decoded D-stage fields. A multi-cycle mult/div unit (MDU) is also
//   tracked, so that HI/LO users are held in D while the unit is busy.
//
//   Ports
//     clk, reset                     rising-edge clock, synchronous active-low reset
//     rs_D, rt_D                     source registers of the D instruction
//     tuse_rs_D, tuse_rt_D           cycles until each source is consumed (0 = in D)
//     a3_D, tnew_D                   destination register (0 = none), cycles after E until result
//     md_start_D, md_is_div_D        D instruction launches the MDU (div when md_is_div_D)
//     md_use_D                       D instruction touches HI/LO or starts the MDU
//     ForwardRSD/RTD                 000 GRF, 001 E, 010 M, 011 W (W only when GRF_BYPASS=0)
//     ForwardRSE/RTE                 000 pipe reg, 001 M, 010 W
//     ForwardRTM                     000 pipe reg, 001 W
//     stall                          freeze PC and F/D, bubble into E
//     md_busy                        MDU busy
module hazard_scoreboard #(
  parameter int REG_W       = 5,
  parameter int T_W         = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int GRF_BYPASS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_D,
  input  logic [REG_W-1:0] rt_D,
  input  logic [T_W-1:0]   tuse_rs_D,
  input  logic [T_W-1:0]   tuse_rt_D,
  input  logic [REG_W-1:0] a3_D,
  input  logic [T_W-1:0]   tnew_D,
  input  logic             md_start_D,
  input  logic             md_is_div_D,
  input  logic             md_use_D,
  output logic [2:0]       ForwardRSD,
  output logic [2:0]       ForwardRTD,
  output logic [2:0]       ForwardRSE,
  output logic [2:0]       ForwardRTE,
  output logic [2:0]       ForwardRTM,
  output logic             stall,
  output logic             md_busy
);

  // The counter is sized for the longer of the two operations, so a
  // MULT_CYCLES larger than DIV_CYCLES still loads without truncation.
  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic             W_TO_D    = (GRF_BYPASS == 0);

  // E stage: full record. M keeps rt for the store-data forward into M.
  // W only needs what forwarding/stalling compare against.
  logic [REG_W-1:0] e_a3_q, e_a3_d, e_rs_q, e_rs_d, e_rt_q, e_rt_d;
  logic [T_W-1:0]   e_tnew_q, e_tnew_d;
  logic             e_md_q, e_md_d, e_div_q, e_div_d;
  logic [REG_W-1:0] m_a3_q, m_a3_d, m_rt_q, m_rt_d;
  logic [T_W-1:0]   m_tnew_q, m_tnew_d;
  logic [REG_W-1:0] w_a3_q, w_a3_d;
  logic [T_W-1:0]   w_tnew_q, w_tnew_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic stall_data;
  logic stall_md;

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
    return (x == '0) ? '0 : x - 1'b1;
  endfunction

  // Register 0 is hard-wired, so it never produces a match.
  function automatic logic match(input logic [REG_W-1:0] a3, input logic [REG_W-1:0] r);
    return (a3 != '0) && (a3 == r);
  endfunction

  always_comb begin
    stall_data = (match(e_a3_q, rs_D) && (e_tnew_q > tuse_rs_D)) ||
                 (match(e_a3_q, rt_D) && (e_tnew_q > tuse_rt_D)) ||
                 (match(m_a3_q, rs_D) && (m_tnew_q > tuse_rs_D)) ||
                 (match(m_a3_q, rt_D) && (m_tnew_q > tuse_rt_D)) ||
                 (match(w_a3_q, rs_D) && (w_tnew_q > tuse_rs_D)) ||
                 (match(w_a3_q, rt_D) && (w_tnew_q > tuse_rt_D));
    md_busy  = e_md_q || (md_cnt_q != '0);
    stall_md = md_use_D && md_busy;
    stall    = stall_data || stall_md;
  end

  // Forward selects: a source only forwards once its result exists
  // (tnew == 0); the nearest stage wins.
  always_comb begin
    ForwardRSD = 3'b000;
    if (match(e_a3_q, rs_D) && (e_tnew_q == '0))                 ForwardRSD = 3'b001;
    else if (match(m_a3_q, rs_D) && (m_tnew_q == '0))            ForwardRSD = 3'b010;
    else if (W_TO_D && match(w_a3_q, rs_D) && (w_tnew_q == '0))  ForwardRSD = 3'b011;

    ForwardRTD = 3'b000;
    if (match(e_a3_q, rt_D) && (e_tnew_q == '0))                 ForwardRTD = 3'b001;
    else if (match(m_a3_q, rt_D) && (m_tnew_q == '0))            ForwardRTD = 3'b010;
    else if (W_TO_D && match(w_a3_q, rt_D) && (w_tnew_q == '0))  ForwardRTD = 3'b011;

    ForwardRSE = 3'b000;
    if (match(m_a3_q, e_rs_q) && (m_tnew_q == '0))               ForwardRSE = 3'b001;
    else if (match(w_a3_q, e_rs_q) && (w_tnew_q == '0))          ForwardRSE = 3'b010;

    ForwardRTE = 3'b000;
    if (match(m_a3_q, e_rt_q) && (m_tnew_q == '0))               ForwardRTE = 3'b001;
    else if (match(w_a3_q, e_rt_q) && (w_tnew_q == '0))          ForwardRTE = 3'b010;

    ForwardRTM = 3'b000;
    if (match(w_a3_q, m_rt_q) && (w_tnew_q == '0))               ForwardRTM = 3'b001;
  end

  // Shadow pipeline advance. A stalled D instruction is replaced by an
  // all-zero bubble; that also clears the MDU start bit, so a held
  // md_start_D cannot launch the unit a second time.
  always_comb begin
    e_a3_d   = stall ? '0   : a3_D;
    e_tnew_d = stall ? '0   : tnew_D;
    e_rs_d   = stall ? '0   : rs_D;
    e_rt_d   = stall ? '0   : rt_D;
    e_md_d   = stall ? 1'b0 : md_start_D;
    e_div_d  = stall ? 1'b0 : md_is_div_D;

    m_a3_d   = e_a3_q;
    m_tnew_d = sat_dec(e_tnew_q);
    m_rt_d   = e_rt_q;

    w_a3_d   = m_a3_q;
    w_tnew_d = sat_dec(m_tnew_q);

    // The MDU operation is considered launched as it leaves E.
    md_cnt_d = md_cnt_q;
    if (e_md_q)                md_cnt_d = e_div_q ? DIV_LOAD : MULT_LOAD;
    else if (md_cnt_q != '0)   md_cnt_d = md_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_a3_q   <= '0;
      e_tnew_q <= '0;
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      e_md_q   <= 1'b0;
      e_div_q  <= 1'b0;
      m_a3_q   <= '0;
      m_tnew_q <= '0;
      m_rt_q   <= '0;
      w_a3_q   <= '0;
      w_tnew_q <= '0;
      md_cnt_q <= '0;
    end else begin
      e_a3_q   <= e_a3_d;
      e_tnew_q <= e_tnew_d;
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_md_q   <= e_md_d;
      e_div_q  <= e_div_d;
      m_a3_q   <= m_a3_d;
      m_tnew_q <= m_tnew_d;
      m_rt_q   <= m_rt_d;
      w_a3_q   <= w_a3_d;
      w_tnew_q <= w_tnew_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (GRF_BYPASS=1 and 0) share the
// same D-stage stimulus. Expected values come from an age-based model of the
// last three issued instructions and a cycle-stamp model of the MDU.
module tb_hazard_scoreboard;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rs_D = '0, rt_D = '0, a3_D = '0;
  logic [2:0] tuse_rs_D = '0, tuse_rt_D = '0, tnew_D = '0;
  logic       md_start_D = 1'b0, md_is_div_D = 1'b0, md_use_D = 1'b0;

  logic [2:0] f_rsd, f_rtd, f_rse, f_rte, f_rtm;
  logic       stall, md_busy;
  logic [2:0] nb_rsd, nb_rtd, nb_rse, nb_rte, nb_rtm;
  logic       nb_stall, nb_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  hazard_scoreboard #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .GRF_BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .a3_D(a3_D), .tnew_D(tnew_D),
    .md_start_D(md_start_D), .md_is_div_D(md_is_div_D), .md_use_D(md_use_D),
    .ForwardRSD(f_rsd), .ForwardRTD(f_rtd), .ForwardRSE(f_rse), .ForwardRTE(f_rte),
    .ForwardRTM(f_rtm), .stall(stall), .md_busy(md_busy)
  );

  hazard_scoreboard #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .GRF_BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .a3_D(a3_D), .tnew_D(tnew_D),
    .md_start_D(md_start_D), .md_is_div_D(md_is_div_D), .md_use_D(md_use_D),
    .ForwardRSD(nb_rsd), .ForwardRTD(nb_rtd), .ForwardRSE(nb_rse), .ForwardRTE(nb_rte),
    .ForwardRTM(nb_rtm), .stall(nb_stall), .md_busy(nb_busy)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0] a3;
    logic [2:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } instr_t;

  // hist[0] = issued last cycle (age 0, in E), hist[1] age 1, hist[2] age 2.
  instr_t hist[$];
  int     cyc        = 0;
  int     busy_until = 0;

  function automatic int remaining(int k);
    return (int'(hist[k].tnew) > k) ? int'(hist[k].tnew) - k : 0;
  endfunction

  function automatic bit produces(int k, logic [4:0] r);
    return (hist[k].a3 != 5'd0) && (hist[k].a3 == r);
  endfunction

  function automatic bit m_busy();
    return cyc < busy_until;
  endfunction

  function automatic bit m_stall();
    bit s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (produces(k, rs_D) && remaining(k) > int'(tuse_rs_D)) s = 1'b1;
      if (produces(k, rt_D) && remaining(k) > int'(tuse_rt_D)) s = 1'b1;
    end
    return s || (md_use_D && m_busy());
  endfunction

  // Forward into D: nearest ready producer; W only when the GRF does not bypass.
  function automatic logic [2:0] m_fwd_d(logic [4:0] r, bit bypass);
    int last = bypass ? 1 : 2;
    for (int k = 0; k <= last; k++)
      if (produces(k, r) && remaining(k) == 0) return 3'(k + 1);
    return 3'b000;
  endfunction

  // Forward into E for the instruction of age 0 from age 1 (M) or age 2 (W).
  function automatic logic [2:0] m_fwd_e(logic [4:0] r);
    for (int k = 1; k <= 2; k++)
      if (produces(k, r) && remaining(k) == 0) return 3'(k);
    return 3'b000;
  endfunction

  function automatic logic [2:0] m_fwd_m(logic [4:0] r);
    return (produces(2, r) && remaining(2) == 0) ? 3'b001 : 3'b000;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_d(input int a3, input int tn, input int rs, input int rt,
                       input int urs, input int urt, input bit mds, input bit mdd,
                       input bit mdu);
    a3_D = 5'(a3);  tnew_D = 3'(tn);  rs_D = 5'(rs);  rt_D = 5'(rt);
    tuse_rs_D = 3'(urs);  tuse_rt_D = 3'(urt);
    md_start_D = mds;  md_is_div_D = mdd;  md_use_D = mdu;
  endtask

  // One clock edge, with the model advanced by the same rules.
  task automatic step();
    bit     st;
    instr_t ni;
    st = m_stall();
    ni = st ? '0 : '{a3: a3_D, tnew: tnew_D, rs: rs_D, rt: rt_D};
    @(posedge clk);
    if (!reset) begin
      hist = {};
      repeat (3) hist.push_back('0);
      busy_until = 0;
    end else begin
      if (!st && md_start_D) busy_until = cyc + 2 + (md_is_div_D ? DIV_N : MULT_N);
      hist.push_front(ni);
      void'(hist.pop_back());
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_d(7, 3, 7, 7, 0, 0, 1'b0, 1'b0, 1'b1);
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({stall, md_busy, f_rsd, f_rtd, f_rse, f_rte, f_rtm} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got stall=%b busy=%b fwd=%o%o%o%o%o required all 0",
               stall, md_busy, f_rsd, f_rtd, f_rse, f_rte, f_rtm);
    end
    n_checks++;
    if ({nb_stall, nb_busy, nb_rsd, nb_rtd, nb_rse, nb_rte, nb_rtm} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_nb: got stall=%b busy=%b required 0", nb_stall, nb_busy);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(1, 2, 2, 0, 1, 7, 1'b0, 1'b0, 1'b0);   // lw $1
    step();
    set_d(4, 1, 1, 2, 1, 1, 1'b0, 1'b0, 1'b0);   // addu $4,$1,$2
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %b required 1", stall); end
    step();
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release: got %b required 0", stall); end
    step();
    set_d(0, 0, 0, 0, 7, 7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    // addu now in E, lw has aged into W with its result ready.
    n_checks++;
    if (f_rse !== 3'b010) begin n_fail++; $display("FAIL load_use_fwd_rse: got %b required 010", f_rse); end
  endtask

  task automatic test_branch_fwd();
    do_reset();
    set_d(3, 1, 1, 2, 1, 1, 1'b0, 1'b0, 1'b0);   // addu $3
    step();
    set_d(0, 0, 3, 0, 0, 0, 1'b0, 1'b0, 1'b0);   // beq $3,$0
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL branch_stall: got %b required 1", stall); end
    step();
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL branch_release: got %b required 0", stall); end
    n_checks++;
    if (f_rsd !== 3'b010) begin n_fail++; $display("FAIL branch_fwd_rsd: got %b required 010", f_rsd); end
  endtask

  task automatic test_r0();
    do_reset();
    set_d(0, 3, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      set_d(0, 2, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if ({stall, f_rsd, f_rtd, f_rse, f_rte, f_rtm, nb_rsd, nb_rtd} !== 22'd0) begin
        n_fail++;
        $display("FAIL r0_outputs cycle %0d: got stall=%b fwd=%o%o%o%o%o required all 0",
                 i, stall, f_rsd, f_rtd, f_rse, f_rte, f_rtm);
      end
      step();
    end
  endtask

  task automatic test_mdu();
    int n;
    for (int mode = 1; mode >= 0; mode--) begin
      do_reset();
      set_d(0, 0, 2, 3, 1, 1, 1'b1, mode[0], 1'b1);   // div / mult
      step();
      set_d(8, 1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);      // mfhi $8
      n = 0;
      @(negedge clk);
      while (stall === 1'b1 && n < 60) begin
        n_checks++;
        if (md_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL mdu_busy_during mode %0d cycle %0d: got %b required 1", mode, n, md_busy);
        end
        n++;
        step();
        @(negedge clk);
      end
      n_checks++;
      if (n != (mode ? DIV_N + 1 : MULT_N + 1)) begin
        n_fail++;
        $display("FAIL mdu_stall_cycles mode %0d: got %0d required %0d",
                 mode, n, mode ? DIV_N + 1 : MULT_N + 1);
      end
      n_checks++;
      if (md_busy !== 1'b0) begin n_fail++; $display("FAIL mdu_idle mode %0d: got %b required 0", mode, md_busy); end
    end
  endtask

  task automatic test_w_forward();
    do_reset();
    set_d(5, 1, 0, 0, 1, 1, 1'b0, 1'b0, 1'b0);   // ori $5
    step();
    set_d(0, 0, 0, 0, 7, 7, 1'b0, 1'b0, 1'b0);
    step();
    step();
    set_d(0, 0, 5, 0, 0, 0, 1'b0, 1'b0, 1'b0);   // D reads $5, ori in W
    @(negedge clk);
    n_checks++;
    if (nb_rsd !== 3'b011) begin n_fail++; $display("FAIL w_fwd_no_bypass: got %b required 011", nb_rsd); end
    n_checks++;
    if (f_rsd !== 3'b000) begin n_fail++; $display("FAIL w_fwd_bypass: got %b required 000", f_rsd); end
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL w_fwd_stall: got %b required 0", stall); end
  endtask

  task automatic test_reset_mid_div();
    do_reset();
    set_d(0, 0, 2, 3, 1, 1, 1'b1, 1'b1, 1'b1);   // div
    step();
    set_d(8, 1, 2, 3, 0, 0, 1'b0, 1'b0, 1'b1);   // mfhi held behind it
    repeat (3) step();
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL mid_div_stall: got %b required 1", stall); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({md_busy, stall, f_rsd, f_rtd, f_rse, f_rte, f_rtm} !== 17'd0) begin
      n_fail++;
      $display("FAIL mid_div_reset: got busy=%b stall=%b fwd=%o%o%o%o%o required all 0",
               md_busy, stall, f_rsd, f_rtd, f_rse, f_rte, f_rtm);
    end
  endtask

  task automatic test_random();
    logic [2:0] e_rsd, e_rtd, e_nrsd, e_nrtd, e_rse, e_rte, e_rtm;
    bit         e_stall, e_busy, mds;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) != 0);
      mds   = ($urandom_range(0, 9) == 0);
      set_d($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4),
            mds, $urandom_range(0, 1), mds || ($urandom_range(0, 5) == 0));
      @(negedge clk);
      e_stall = m_stall();
      e_busy  = m_busy();
      e_rsd   = m_fwd_d(rs_D, 1'b1);
      e_rtd   = m_fwd_d(rt_D, 1'b1);
      e_nrsd  = m_fwd_d(rs_D, 1'b0);
      e_nrtd  = m_fwd_d(rt_D, 1'b0);
      e_rse   = m_fwd_e(hist[0].rs);
      e_rte   = m_fwd_e(hist[0].rt);
      e_rtm   = m_fwd_m(hist[1].rt);
      n_checks++;
      if (stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall i=%0d: got %b required %b", i, stall, e_stall); end
      n_checks++;
      if (md_busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy i=%0d: got %b required %b", i, md_busy, e_busy); end
      n_checks++;
      if (f_rsd !== e_rsd) begin n_fail++; $display("FAIL rnd_rsd i=%0d: got %b required %b", i, f_rsd, e_rsd); end
      n_checks++;
      if (f_rtd !== e_rtd) begin n_fail++; $display("FAIL rnd_rtd i=%0d: got %b required %b", i, f_rtd, e_rtd); end
      n_checks++;
      if (nb_rsd !== e_nrsd) begin n_fail++; $display("FAIL rnd_nb_rsd i=%0d: got %b required %b", i, nb_rsd, e_nrsd); end
      n_checks++;
      if (nb_rtd !== e_nrtd) begin n_fail++; $display("FAIL rnd_nb_rtd i=%0d: got %b required %b", i, nb_rtd, e_nrtd); end
      n_checks++;
      if (f_rse !== e_rse) begin n_fail++; $display("FAIL rnd_rse i=%0d: got %b required %b", i, f_rse, e_rse); end
      n_checks++;
      if (f_rte !== e_rte) begin n_fail++; $display("FAIL rnd_rte i=%0d: got %b required %b", i, f_rte, e_rte); end
      n_checks++;
      if (f_rtm !== e_rtm) begin n_fail++; $display("FAIL rnd_rtm i=%0d: got %b required %b", i, f_rtm, e_rtm); end
      n_checks++;
      if ({nb_stall, nb_busy, nb_rse, nb_rte, nb_rtm} !== {e_stall, e_busy, e_rse, e_rte, e_rtm}) begin
        n_fail++;
        $display("FAIL rnd_nb_misc i=%0d: got %b required %b", i,
                 {nb_stall, nb_busy, nb_rse, nb_rte, nb_rtm}, {e_stall, e_busy, e_rse, e_rte, e_rtm});
      end
      step();
    end
    reset = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    repeat (3) hist.push_back('0);
    test_reset();
    test_load_use();
    test_branch_fwd();
    test_r0();
    test_mdu();
    test_w_forward();
    test_reset_mid_div();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
